// File: rtl/mmu09_pkg.sv
// rtl/mmu09_pkg.sv - shared constants for the MMU09 context loader
//
// Purpose: offsets within the $FF70-$FF7F I/O window and the loader state
// encoding, shared by the loader top and its bench.
// Ports: none (package).

package mmu09_pkg;

  // Offsets within the $FF7x window (i_addr[3:0]).
  localparam logic [3:0] PTE_STAGE = 4'h0;   // 0..7: staged entries
  localparam logic [3:0] CTX_STAGE = 4'h8;
  localparam logic [3:0] CTX_LOAD  = 4'h9;
  localparam logic [3:0] CTX_STAT  = 4'hA;

  // Loader sequencer states.
  localparam logic [1:0] ST_IDLE    = 2'b00;
  localparam logic [1:0] ST_HALTREQ = 2'b01;
  localparam logic [1:0] ST_COPY    = 2'b10;
  localparam logic [1:0] ST_RELEASE = 2'b11;

  // Offsets 0..7 address a staged entry; bit 3 splits them from control.
  function automatic logic is_pte_stage(input logic [3:0] a);
    return (a & 4'h8) == PTE_STAGE;
  endfunction

endpackage

// File: rtl/pte_ctx_ram.sv
// rtl/pte_ctx_ram.sv - staged page-table banks, NCTX x 8 x 8 bits
//
// Purpose: holds the kernel-staged entries for every context bank.
// Ports:
//   clk          - E clock
//   we/wctx/widx/wdata - synchronous staging write port
//   rctx/ridx    - asynchronous read address (copy sequencer)
//   rdata        - entry at {rctx, ridx}
// Storage is deliberately not reset.

module pte_ctx_ram #(
  parameter int NCTX = 4,
  parameter int CTXW = 2
) (
  input  logic            clk,
  input  logic            we,
  input  logic [CTXW-1:0] wctx,
  input  logic [2:0]      widx,
  input  logic [7:0]      wdata,
  input  logic [CTXW-1:0] rctx,
  input  logic [2:0]      ridx,
  output logic [7:0]      rdata
);

  logic [7:0] mem [NCTX*8];

  always_ff @(posedge clk) begin
    if (we) mem[{wctx, widx}] <= wdata;
  end

  assign rdata = mem[{rctx, ridx}];

endmodule

// File: rtl/pte_ctx_loader.sv
// rtl/pte_ctx_loader.sv - halts the 6809 and copies a staged bank into the live MMU table
//
// Purpose: kernel stages entries at $FF70-$FF77, selects the staging bank at
// $FF78, and writes $FF79 to activate a bank. The loader halts the CPU,
// waits for BA&BS, streams 8 entries to the live page table, then releases.
// Ports:
//   i_eclk, i_reset      - E clock, synchronous active-low reset
//   i_sel, i_rw, i_addr, i_data - CPU access to the $FF7x window
//   i_ba, i_bs           - halt acknowledge from the 6809
//   o_data, o_oe         - status read data and bus drive enable
//   halt_n               - 6809 HALT line
//   pte_we, pte_idx, pte_data - registered live page table write port
//   busy, active_ctx     - sequencer not idle / last bank loaded

module pte_ctx_loader
  import mmu09_pkg::*;
#(
  parameter int NCTX = 4,
  parameter int CTXW = 2
) (
  input  logic            i_eclk,
  input  logic            i_reset,
  input  logic            i_sel,
  input  logic            i_rw,
  input  logic [3:0]      i_addr,
  input  logic [7:0]      i_data,
  input  logic            i_ba,
  input  logic            i_bs,
  output logic [7:0]      o_data,
  output logic            o_oe,
  output logic            halt_n,
  output logic            pte_we,
  output logic [2:0]      pte_idx,
  output logic [7:0]      pte_data,
  output logic            busy,
  output logic [CTXW-1:0] active_ctx
);

  logic [1:0]      state;
  logic            ovr;
  logic [CTXW-1:0] stage_ctx;
  logic [CTXW-1:0] load_ctx;
  logic [2:0]      rd_idx;
  logic [7:0]      rd_data;
  logic            reg_wr;
  logic            stat_rd;
  logic            stage_we;

  assign busy     = (state != ST_IDLE);
  // Only offsets 0..9 are registers; writes elsewhere are silently dropped.
  assign reg_wr   = i_sel & ~i_rw & (i_addr <= CTX_LOAD);
  assign stat_rd  = i_sel & i_rw & (i_addr == CTX_STAT);
  assign stage_we = reg_wr & ~busy & is_pte_stage(i_addr);

  assign o_oe   = stat_rd;
  assign o_data = stat_rd ? {busy, ovr, 2'b00, 4'(active_ctx)} : 8'h00;

  // pte_idx doubles as the copy counter k; the RAM is addressed one entry
  // ahead so the next value is ready to register on the following edge.
  assign rd_idx = (state == ST_COPY) ? pte_idx + 3'd1 : 3'd0;

  pte_ctx_ram #(.NCTX(NCTX), .CTXW(CTXW)) u_ram (
    .clk   (i_eclk),
    .we    (stage_we),
    .wctx  (stage_ctx),
    .widx  (i_addr[2:0]),
    .wdata (i_data),
    .rctx  (load_ctx),
    .ridx  (rd_idx),
    .rdata (rd_data)
  );

  always_ff @(posedge i_eclk) begin
    if (!i_reset) begin
      state      <= ST_IDLE;
      halt_n     <= 1'b1;
      pte_we     <= 1'b0;
      pte_idx    <= 3'd0;
      pte_data   <= 8'h00;
      ovr        <= 1'b0;
      stage_ctx  <= '0;
      load_ctx   <= '0;
      active_ctx <= '0;
    end else begin
      // A write and a status read cannot share an edge (R/W differs).
      if (reg_wr && busy) ovr <= 1'b1;
      else if (stat_rd)   ovr <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (reg_wr && i_addr == CTX_STAGE) stage_ctx <= i_data[CTXW-1:0];
          if (reg_wr && i_addr == CTX_LOAD) begin
            load_ctx <= i_data[CTXW-1:0];
            halt_n   <= 1'b0;
            state    <= ST_HALTREQ;
          end
        end
        ST_HALTREQ: begin
          if (i_ba && i_bs) begin
            pte_we   <= 1'b1;
            pte_idx  <= 3'd0;
            pte_data <= rd_data;
            state    <= ST_COPY;
          end
        end
        ST_COPY: begin
          if (pte_idx == 3'd7) begin
            pte_we <= 1'b0;
            state  <= ST_RELEASE;
          end else begin
            pte_idx  <= pte_idx + 3'd1;
            pte_data <= rd_data;
          end
        end
        default: begin
          active_ctx <= load_ctx;
          halt_n     <= 1'b1;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/pte_ctx_loader.md
# pte_ctx_loader

Page-table context loader for the MMU09 board. Holds `NCTX` banks of eight staged page table entries, written by the kernel through the $FF70–$FF7F I/O region. On an "activate" command it halts the 6809, waits for halt acknowledge, then copies the selected bank into the live MMU page table one entry per E cycle, and releases the CPU. This makes a user context switch a single kernel store.

## Interface

Parameters:
- `NCTX`, 4: number of context banks (power of two, 2..16).
- `CTXW`, 2: bank index width, equal to log2(`NCTX`).

Ports:
- `i_eclk` in 1: 6809 E clock; all state changes on its rising edge.
- `i_reset` in 1: reset; one clock; reset is synchronous and active-low.
- `i_sel` in 1: high when address is $FFxx, I/O is mapped, and `i_addr[7:4]==4'h7`.
- `i_rw` in 1: 6809 R/W (1 = read).
- `i_addr` in 4: low address bits `i_addr[3:0]`.
- `i_data` in 8: CPU data bus.
- `i_ba` in 1: 6809 BA.
- `i_bs` in 1: 6809 BS.
- `o_data` out 8: status read data.
- `o_oe` out 1: drive `o_data` onto the bus.
- `halt_n` out 1: to the 6809 HALT line.
- `pte_we` out 1: live page table write strobe.
- `pte_idx` out 3: live page table entry index.
- `pte_data` out 8: live page table entry value (bit 7 = invalid, bits 5:0 = frame).
- `busy` out 1: sequencer not IDLE.
- `active_ctx` out `CTXW`: bank most recently loaded.

## Operation

Register map. Writes take effect when `i_sel & !i_rw` is high at the rising edge.
- $FF70–$FF77: write staged entry `bank[stage_ctx][i_addr[2:0]] <= i_data`.
- $FF78: `stage_ctx <= i_data[CTXW-1:0]`.
- $FF79: activate; `load_ctx <= i_data[CTXW-1:0]`, then go IDLE→HALTREQ.
- $FF7A read: `o_data = {busy, ovr, 2'b00, active_ctx zero-extended to 4}`, with `o_oe=1`. The read clears `ovr` at the edge.
- Other offsets: writes are ignored, reads give `o_oe=0`.

State machine (registered):
- **IDLE**: `halt_n=1`, `pte_we=0`. An activate write moves to HALTREQ.
- **HALTREQ**: `halt_n=0`. On the first edge with `i_ba & i_bs` set, go to COPY with counter k=0.
- **COPY**: `pte_we=1`, `pte_idx=k`, `pte_data=bank[load_ctx][k]`. k increments each edge. After k=7 go to RELEASE.
- **RELEASE**: `pte_we=0`, `halt_n=0`. Set `active_ctx <= load_ctx`, then go to IDLE.

Boundary rules:
- Any register write while `busy` (the CPU may finish its current instruction in HALTREQ) is discarded and sets `ovr`. This includes a second activate.
- Activating the bank equal to `active_ctx` is allowed and performs a full copy.
- `stage_ctx` may equal `load_ctx`. There is no conflict, because staging writes are blocked while busy.
- A reset in any state, including mid-COPY, returns to IDLE on that edge. Reset values: `halt_n=1`, `pte_we=0`, `pte_idx=0`, `pte_data=0`, `busy=0`, `ovr=0`, `stage_ctx=0`, `load_ctx=0`, `active_ctx=0`. Bank storage is not reset. A partial copy is left as-is; the kernel reloads after reset.

## Timing

- If the activate write is at edge N, `halt_n` goes low after edge N.
- If the acknowledge is first seen at edge A, `pte_we` is high for exactly the 8 cycles following edges A..A+7, with `pte_idx` 0..7 in order. The page table captures each entry on the next edge.
- RELEASE lasts the cycle after edge A+8. `halt_n` returns high after edge A+9.
- `pte_*` are registered outputs. `o_data`/`o_oe` are combinational from `i_sel`, `i_rw` and `i_addr`.
- No timeout: HALTREQ waits indefinitely for acknowledge.

## Structure

- Shared package `mmu09_pkg`: region offset constants (`PTE_STAGE`=0–7, `CTX_STAGE`=8, `CTX_LOAD`=9, `CTX_STAT`=10) and a 2-bit state encoding (IDLE=00, HALTREQ=01, COPY=10, RELEASE=11).
- One sub-module, `pte_ctx_ram`: an `NCTX`×8×8-bit array with one synchronous write port (staging) and one asynchronous read port (copy). The FSM, registers and status live in the top.

## Test plan

- Reset, stage bank 2 with $00..$07 (entry 3 = $83), activate bank 2, raise `i_ba`/`i_bs` two cycles later. Expect 8 `pte_we` cycles with idx 0..7 and data $00,$01,$02,$83,$04..$07, `halt_n` high 2 cycles after the last strobe, and status read = $02.
- Activate, then hold `i_ba`=0 for 20 cycles. Expect `halt_n`=0, `pte_we`=0 and `busy`=1 throughout, then the copy begins on the acknowledge edge.
- Write to $FF72 and $FF79 while in HALTREQ. Expect `ovr`=1, bank contents unchanged, and only one copy. Status read returns bit 6 set, and the next read returns bit 6 clear.
- Assert `i_reset`=0 during COPY at k=4. On that edge expect `pte_we`=0, `halt_n`=1, `busy`=0, and status = $00.
- Stage bank 0 and bank 3 with distinct values, activate 3 then 0. Expect each copy to reflect its own bank and `active_ctx` to track 3 then 0.
- Read $FF7B and write $FF7F. Expect `o_oe`=0 and no state change.
